bit_serializer: RTL and testbench

- Parallel-to-serial front end that feeds the single-bit `in` input of the 0101/0110 pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Between words, drives a fixed idle level so the downstream detector always sees a defined bit.

---
 rtl/ser_pkg.sv | 15 +
 rtl/ser_hold_buf.sv | 46 ++++
 rtl/bit_serializer.sv | 165 ++++++++++++++++
 tb/tb_bit_serializer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and defaults for the bit serializer
//
// Purpose: FSM state encoding and default parameter values used by
//          bit_serializer and ser_hold_buf.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_WIDTH    = 8;
  localparam bit SER_IDLE_BIT = 1'b1;

endpackage

// File: rtl/ser_hold_buf.sv
// rtl/ser_hold_buf.sv - one-entry word hold register with full flag
//
// Purpose: parks one accepted word while the shifter is still busy so the
//          next word can start without an idle gap.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset, empties the entry
//   push       in   write push_data into the entry (allowed while popping)
//   push_data  in   word to store
//   pop        in   consume the stored word
//   full       out  entry holds a word
//   data       out  stored word
module ser_hold_buf
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (push) begin
        data_q <= push_data;
      end
      // A push in the same cycle as a pop refills the entry.
      full_q <= push | (full_q & ~pop);
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end for the pattern detector
//
// Purpose: accepts WIDTH-bit words on a valid/ready handshake and shifts them
//          out one bit per clock; drives IDLE_BIT between words.
//          Optional gapless operation with a one-entry hold register when
//          BIT_SERIALIZER_PREFETCH_EN is defined.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   s_valid    in   upstream word valid
//   s_ready    out  word can be accepted this cycle
//   s_data     in   word to serialize, sampled on s_valid && s_ready
//   bit_out    out  serial bit (registered)
//   bit_valid  out  bit_out carries word data (registered)
//   word_done  out  last bit of a word is on bit_out
//   busy       out  shifting or a word is held (registered)
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_out_q, bit_valid_q, busy_q;
  logic             busy_d;
  logic             last;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

`ifdef BIT_SERIALIZER_PREFETCH_EN
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_push, hold_pop;

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .push     (hold_push),
    .push_data(s_data),
    .pop      (hold_pop),
    .full     (hold_full),
    .data     (hold_data)
  );

  assign s_ready = !hold_full;
`else
  assign s_ready = (state_q == IDLE);
`endif

  assign last      = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign word_done = last;
  assign accept    = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef BIT_SERIALIZER_PREFETCH_EN
    hold_push = 1'b0;
    hold_pop  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // The hold entry is always empty here, so accepts go straight to the shifter.
        if (accept) begin
          state_d = SHIFT;
          shreg_d = s_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!last) begin
          shreg_d = shift_once(shreg_q);
          cnt_d   = cnt_q + CW'(1);
`ifdef BIT_SERIALIZER_PREFETCH_EN
          hold_push = accept;
`endif
        end else begin
`ifdef BIT_SERIALIZER_PREFETCH_EN
          if (hold_full) begin
            shreg_d   = hold_data;
            cnt_d     = '0;
            hold_pop  = 1'b1;
            hold_push = accept;
          end else if (accept) begin
            // Bypass: nothing held, so the new word lands in the shifter directly.
            shreg_d = s_data;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
`else
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BIT_SERIALIZER_PREFETCH_EN
  assign busy_d = (state_d == SHIFT) || hold_push || (hold_full && !hold_pop);
`else
  assign busy_d = (state_d == SHIFT);
`endif

  // Serial outputs are registered from the next-state values so they change
  // only on the clock edge and carry the new head bit in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      bit_out_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= (state_d == SHIFT) ? head_bit(shreg_d) : IDLE_BIT;
      bit_valid_q <= (state_d == SHIFT);
      busy_q      <= busy_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic [7:0] s_data;

  logic m_ready, m_bit, m_bv, m_done, m_busy;
  logic l_ready, l_bit, l_bv, l_done, l_busy;

  int n_vec = 0;
  int n_err = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(m_ready), .s_data(s_data),
    .bit_out(m_bit), .bit_valid(m_bv), .word_done(m_done), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(l_ready), .s_data(s_data),
    .bit_out(l_bit), .bit_valid(l_bv), .word_done(l_done), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit use_lsb, input logic bo,
                         input logic bv, input logic wd, input logic rdy, input logic bsy);
    if (use_lsb) begin
      chk({tag, ".bit_out"}, l_bit, bo);
      chk({tag, ".bit_valid"}, l_bv, bv);
      chk({tag, ".word_done"}, l_done, wd);
      chk({tag, ".s_ready"}, l_ready, rdy);
      chk({tag, ".busy"}, l_busy, bsy);
    end else begin
      chk({tag, ".bit_out"}, m_bit, bo);
      chk({tag, ".bit_valid"}, m_bv, bv);
      chk({tag, ".word_done"}, m_done, wd);
      chk({tag, ".s_ready"}, m_ready, rdy);
      chk({tag, ".busy"}, m_busy, bsy);
    end
  endtask

  // Offer a word; it is accepted on the next edge (block must be idle).
  task automatic send(input logic [7:0] d, input bit keep_valid);
    s_valid = 1'b1;
    s_data  = d;
    step();
    if (!keep_valid) s_valid = 1'b0;
  endtask

  // seq lists the expected serial bits in emission order, leftmost first.
  // Optionally raise s_valid with raise_data after checking bit raise_at.
  task automatic expect_word(input string tag, input bit use_lsb, input logic [7:0] seq,
                             input int raise_at, input logic [7:0] raise_data);
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("%s.b%0d", tag, i), use_lsb, seq[7-i], 1'b1, (i == 7), 1'b0, 1'b1);
      if (i == raise_at) begin
        s_valid = 1'b1;
        s_data  = raise_data;
      end
      step();
    end
  endtask

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;

    // Reset held for 3 cycles, s_valid ignored while in reset.
    for (int i = 0; i < 3; i++) begin
      step();
      s_valid = (i == 1);
      s_data  = 8'hFF;
      chk_out($sformatf("rst%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    s_valid = 1'b0;
    reset   = 1'b1;

    // Idle after release.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("idle%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Single word, MSB first: 0x56 -> 0,1,0,1,0,1,1,0 then idle '1'.
    send(8'h56, 1'b0);
    expect_word("w56", 1'b0, 8'b0101_0110, -1, 8'h00);
    chk_out("w56.after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB first: 0xA5 -> 1,0,1,0,0,1,0,1.
    send(8'hA5, 1'b0);
    expect_word("wA5", 1'b1, 8'b1010_0101, -1, 8'h00);
    chk_out("wA5.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back with s_valid held: 0x0F then 0xF0, one idle '1' between.
    send(8'h0F, 1'b1);
    expect_word("w0F", 1'b0, 8'b0000_1111, 0, 8'hF0);
    chk_out("gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    s_valid = 1'b0;
    expect_word("wF0", 1'b0, 8'b1111_0000, -1, 8'h00);
    chk_out("wF0.after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: 0x99 offered mid-word, taken only once idle, emitted intact.
    send(8'h3C, 1'b0);
    expect_word("w3C", 1'b0, 8'b0011_1100, 2, 8'h99);
    chk_out("bp.idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    s_valid = 1'b0;
    expect_word("w99", 1'b0, 8'b1001_1001, -1, 8'h00);

    // Async reset between edges after the 3rd bit of 0x56.
    send(8'h56, 1'b0);
    chk_out("ab.b0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("ab.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("ab.b2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_out("ab.rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    chk_out("ab.idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h33, 1'b0);
    expect_word("w33", 1'b0, 8'b0011_0011, -1, 8'h00);
    chk_out("w33.after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
